alu_req_arbiter: RTL and testbench

//  Shares the single combinational alu between NUM_REQ requesters (decoder, address gen, ...).

---
 rtl/alu_req_arbiter_if.sv | 39 +++
 rtl/alu_req_arbiter.sv | 99 +++++++++
 tb/tb_alu_req_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester, alu and response buses of the alu arbiter, plus the pkg_alu op type
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif
package pkg_alu;
  typedef enum logic [2:0] {
    alu_op_add, alu_op_adc, alu_op_sub, alu_op_and,
    alu_op_or, alu_op_xor, alu_op_lslp, alu_op_lsrp
  } alu_oper;
endpackage

interface alu_req_arbiter_if #(parameter int NUM_REQ = 2, parameter int ID_W = 1);
  logic [NUM_REQ-1:0] req_valid, req_ready, req_use_pflags, req_upd_pflags;
  pkg_alu::alu_oper [NUM_REQ-1:0] req_oper;
  logic [NUM_REQ-1:0][`ALU_INOUT_WIDTH-1:0] req_a_lo, req_a_hi, req_b;
  logic [NUM_REQ-1:0][`PROC_FLAGS_WIDTH-1:0] req_flags;
  pkg_alu::alu_oper alu_oper;
  logic [`ALU_INOUT_WIDTH-1:0] alu_a_in_lo, alu_a_in_hi, alu_b_in, alu_out_lo, alu_out_hi;
  logic [`PROC_FLAGS_WIDTH-1:0] alu_proc_flags_in, alu_proc_flags_out;
  logic rsp_valid, rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [`ALU_INOUT_WIDTH-1:0] rsp_lo, rsp_hi;
  logic [`PROC_FLAGS_WIDTH-1:0] rsp_flags, pflags;
  modport master (
    output req_valid, req_oper, req_a_lo, req_a_hi, req_b, req_use_pflags, req_flags, req_upd_pflags,
    output rsp_ready, alu_out_lo, alu_out_hi, alu_proc_flags_out,
    input req_ready, alu_oper, alu_a_in_lo, alu_a_in_hi, alu_b_in, alu_proc_flags_in,
    input rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_flags, pflags
  );
  modport slave (
    input req_valid, req_oper, req_a_lo, req_a_hi, req_b, req_use_pflags, req_flags, req_upd_pflags,
    input rsp_ready, alu_out_lo, alu_out_hi, alu_proc_flags_out,
    output req_ready, alu_oper, alu_a_in_lo, alu_a_in_hi, alu_b_in, alu_proc_flags_in,
    output rsp_valid, rsp_id, rsp_lo, rsp_hi, rsp_flags, pflags
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational alu among NUM_REQ requesters and owns the processor flags.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
`ifndef ALU_INOUT_WIDTH
`define ALU_INOUT_WIDTH 8
`endif
`ifndef PROC_FLAGS_WIDTH
`define PROC_FLAGS_WIDTH 4
`endif
module alu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = 1
) (
  input logic clk,
  input logic rst_n,
  alu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
  state_t state, nxt;
  logic [ID_W-1:0] gnt;
  logic any, upd_q, accept;
`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  // the requester just after rr_ptr has distance 0, so it wins
  always_comb begin
    int best;
    int d;
    best = NUM_REQ;
    d = 0;
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i - int'(rr_ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (bus.req_valid[i] && d < best) begin
        best = d;
        gnt = ID_W'(i);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= ID_W'(NUM_REQ - 1);
    else if (accept) rr_ptr <= gnt;
`else
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i]) begin
        gnt = ID_W'(i);
        any = 1'b1;
      end
  end
`endif
  assign accept = state == S_IDLE && any;
  assign bus.rsp_valid = state == S_RESP;
  always_comb begin
    nxt = state;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[gnt] = 1'b1;
      nxt = S_EXEC;
    end
    else if (state == S_EXEC) nxt = S_RESP;
    else if (state == S_RESP && bus.rsp_ready) nxt = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      bus.alu_oper <= pkg_alu::alu_op_add;
      bus.alu_a_in_lo <= '0;
      bus.alu_a_in_hi <= '0;
      bus.alu_b_in <= '0;
      bus.alu_proc_flags_in <= '0;
      upd_q <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_lo <= '0;
      bus.rsp_hi <= '0;
      bus.rsp_flags <= '0;
      bus.pflags <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        bus.alu_oper <= bus.req_oper[gnt];
        bus.alu_a_in_lo <= bus.req_a_lo[gnt];
        bus.alu_a_in_hi <= bus.req_a_hi[gnt];
        bus.alu_b_in <= bus.req_b[gnt];
        bus.alu_proc_flags_in <= bus.req_use_pflags[gnt] ? bus.pflags : bus.req_flags[gnt];
        upd_q <= bus.req_upd_pflags[gnt];
        bus.rsp_id <= gnt;
      end
      // pflags lands here so a request accepted right after this op sees it
      if (state == S_EXEC) begin
        bus.rsp_lo <= bus.alu_out_lo;
        bus.rsp_hi <= bus.alu_out_hi;
        bus.rsp_flags <= bus.alu_proc_flags_out;
        if (upd_q) bus.pflags <= bus.alu_proc_flags_out;
      end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scoreboard bench with a behavioural alu; flags are {V,N,Z,C}.
module tb_alu_req_arbiter;
  import pkg_alu::*;
  localparam int NR = 2;
  localparam int IW = 1;
  typedef struct packed {logic [IW-1:0] id; logic [7:0] lo; logic [7:0] hi; logic [3:0] fl;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [3:0] pf_m = '0;

  alu_req_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();
  alu_req_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [19:0] alu_f(alu_oper op, logic [7:0] alo, logic [7:0] ahi, logic [7:0] b, logic [3:0] fin);
    logic [8:0] s;
    logic [16:0] w;
    logic [7:0] lo, hi;
    logic c;
    hi = ahi;
    lo = alo & b;
    c = 1'b0;
    s = '0;
    w = '0;
    if (op == alu_op_add) begin s = {1'b0, alo} + {1'b0, b}; lo = s[7:0]; c = s[8]; end
    else if (op == alu_op_adc) begin s = {1'b0, alo} + {1'b0, b} + {8'h00, fin[0]}; lo = s[7:0]; c = s[8]; end
    else if (op == alu_op_lslp) begin w = {1'b0, ahi, alo} << b[3:0]; {c, hi, lo} = w; end
    return {hi, lo, 1'b0, lo[7], lo == 8'h00, c};
  endfunction

  always_comb {bus.alu_out_hi, bus.alu_out_lo, bus.alu_proc_flags_out} =
    alu_f(bus.alu_oper, bus.alu_a_in_lo, bus.alu_a_in_hi, bus.alu_b_in, bus.alu_proc_flags_in);

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic drive_req(input logic [IW-1:0] r, input alu_oper op, input logic [7:0] alo, input logic [7:0] ahi,
                           input logic [7:0] b, input logic use_pf, input logic [3:0] fl, input logic upd, output int cyc);
    logic [19:0] res;
    bus.req_oper[r] = op;
    bus.req_a_lo[r] = alo;
    bus.req_a_hi[r] = ahi;
    bus.req_b[r] = b;
    bus.req_use_pflags[r] = use_pf;
    bus.req_flags[r] = fl;
    bus.req_upd_pflags[r] = upd;
    bus.req_valid[r] = 1'b1;
    cyc = -1;
    for (int t = 0; t < 20 && cyc < 0; t++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin
        cyc = t;
        res = alu_f(op, alo, ahi, b, use_pf ? pf_m : fl);
        sb.push_back('{id: r, lo: res[11:4], hi: res[19:12], fl: res[3:0]});
        if (upd) pf_m = res[3:0];
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid[r] = 1'b0;
    if (cyc < 0) begin n_cmp++; n_err++; $display("FAIL accept_timeout req=%0d got=no_ready want=ready", r); end
  endtask

  task automatic wait_rsp(output int cyc, output exp_t got);
    cyc = -1;
    got = '0;
    for (int t = 0; t < 20 && cyc < 0; t++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        cyc = t;
        got = '{id: bus.rsp_id, lo: bus.rsp_lo, hi: bus.rsp_hi, fl: bus.rsp_flags};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin n_err++; $display("FAIL reset_hs got rsp_valid=%b req_ready=%b want 0/0", bus.rsp_valid, bus.req_ready); end
    n_cmp++; if (bus.pflags !== 4'h0) begin n_err++; $display("FAIL reset_pflags got=%h want=0", bus.pflags); end
    n_cmp++; if (bus.alu_oper !== alu_op_add) begin n_err++; $display("FAIL reset_oper got=%0d want=%0d", bus.alu_oper, alu_op_add); end
    n_cmp++; if ({bus.alu_a_in_lo, bus.alu_a_in_hi, bus.alu_b_in, bus.alu_proc_flags_in} !== 28'h0) begin n_err++; $display("FAIL reset_operands got=%h want=0", {bus.alu_a_in_lo, bus.alu_a_in_hi, bus.alu_b_in, bus.alu_proc_flags_in}); end
    n_cmp++; if ({bus.rsp_id, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags} !== '0) begin n_err++; $display("FAIL reset_rsp got=%h want=0", {bus.rsp_id, bus.rsp_lo, bus.rsp_hi, bus.rsp_flags}); end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    int c;
    exp_t got, e;
    drive_req(1'b0, alu_op_add, 8'h7F, 8'h00, 8'h01, 1'b0, 4'h0, 1'b1, c);
    n_cmp++; if (c != 0) begin n_err++; $display("FAIL add_accept_cycle got=%0d want=0", c); end
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (c != 1) begin n_err++; $display("FAIL add_latency got=%0d want=1 (rsp in cycle 2)", c); end
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL add_rsp got=%h want=%h", got, e); end
    n_cmp++; if (got.lo !== 8'h80 || got.id !== 1'b0 || got.fl[0] !== 1'b0) begin n_err++; $display("FAIL add_literal got lo=%h id=%b c=%b want 80/0/0", got.lo, got.id, got.fl[0]); end
    n_cmp++; if (bus.pflags !== pf_m) begin n_err++; $display("FAIL add_pflags got=%h want=%h", bus.pflags, pf_m); end
  endtask

  task automatic test_adc_chain();
    int c;
    exp_t got, e;
    drive_req(1'b1, alu_op_add, 8'hFF, 8'h00, 8'h01, 1'b0, 4'h0, 1'b1, c);
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (got !== e || got.lo !== 8'h00 || got.id !== 1'b1) begin n_err++; $display("FAIL carry_rsp got=%h want=%h", got, e); end
    n_cmp++; if (bus.pflags[0] !== 1'b1 || bus.pflags !== pf_m) begin n_err++; $display("FAIL carry_pflags got=%h want=%h", bus.pflags, pf_m); end
    drive_req(1'b1, alu_op_adc, 8'h00, 8'h00, 8'h00, 1'b1, 4'h0, 1'b1, c);
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (got !== e || got.lo !== 8'h01) begin n_err++; $display("FAIL adc_rsp got=%h want=%h (lo=01)", got, e); end
    n_cmp++; if (bus.pflags !== pf_m) begin n_err++; $display("FAIL adc_pflags got=%h want=%h", bus.pflags, pf_m); end
  endtask

  task automatic test_arbitration();
    int c;
    exp_t got, e;
    logic [IW-1:0] g;
    logic [19:0] res;
    logic [7:0] alo [NR];
    logic [IW-1:0] want [4];
`ifdef ALU_ARB_RR_EN
    want = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    want = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    alo = '{8'h11, 8'h22};
    rst_n = 1'b0;
    pf_m = '0;
    #2 rst_n = 1'b1;
    for (int r = 0; r < NR; r++) begin
      bus.req_oper[r] = alu_op_add;
      bus.req_a_lo[r] = alo[r];
      bus.req_a_hi[r] = 8'(r);
      bus.req_b[r] = 8'(r + 1);
      bus.req_use_pflags[r] = 1'b0;
      bus.req_flags[r] = 4'h0;
      bus.req_upd_pflags[r] = 1'b0;
    end
    bus.req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      c = -1;
      for (int t = 0; t < 10 && c < 0; t++) begin
        @(negedge clk);
        if (bus.req_ready != '0) c = t;
      end
      g = bus.req_ready[1] ? 1'b1 : 1'b0;
      n_cmp++; if (c < 0 || bus.req_ready !== (NR'(1) << g) || g !== want[k]) begin n_err++; $display("FAIL arb_grant%0d got ready=%b want grant %0d", k, bus.req_ready, want[k]); end
      if (c >= 0) begin
        res = alu_f(alu_op_add, alo[g], {7'b0, g}, {7'b0, g} + 8'd1, 4'h0);
        sb.push_back('{id: g, lo: res[11:4], hi: res[19:12], fl: res[3:0]});
      end
      @(posedge clk);
      #1;
      wait_rsp(c, got);
      e = pop_exp();
      n_cmp++; if (got !== e) begin n_err++; $display("FAIL arb_rsp%0d got=%h want=%h", k, got, e); end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    int c;
    exp_t got, e, now;
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, alu_op_and, 8'hF0, 8'h5A, 8'h3C, 1'b0, 4'h0, 1'b0, c);
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL bp_rsp got=%h want=%h", got, e); end
    bus.req_oper[1] = alu_op_add;
    bus.req_valid[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      now = '{id: bus.rsp_id, lo: bus.rsp_lo, hi: bus.rsp_hi, fl: bus.rsp_flags};
      n_cmp++; if (bus.rsp_valid !== 1'b1 || now !== got || bus.req_ready !== '0) begin n_err++; $display("FAIL bp_hold%0d got valid=%b rsp=%h ready=%b want 1/%h/0", k, bus.rsp_valid, now, bus.req_ready, got); end
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got rsp_valid=%b want=0", bus.rsp_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_exec();
    int c;
    logic saw;
    exp_t got, e;
    drive_req(1'b0, alu_op_add, 8'h10, 8'h00, 8'h20, 1'b0, 4'h0, 1'b1, c);
    rst_n = 1'b0;
    e = pop_exp();
    pf_m = '0;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
      if (k == 1) rst_n = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rstx_rsp got rsp_valid=1 want never"); end
    n_cmp++; if (bus.pflags !== 4'h0) begin n_err++; $display("FAIL rstx_pflags got=%h want=0", bus.pflags); end
    @(posedge clk);
    #1;
    drive_req(1'b1, alu_op_add, 8'h33, 8'h00, 8'h44, 1'b0, 4'h0, 1'b1, c);
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (got !== e || got.lo !== 8'h77) begin n_err++; $display("FAIL rstx_next got=%h want=%h", got, e); end
  endtask

  task automatic test_16bit();
    int c;
    exp_t got, e;
    drive_req(1'b0, alu_op_lslp, 8'h81, 8'h00, 8'h01, 1'b0, 4'h0, 1'b0, c);
    wait_rsp(c, got);
    e = pop_exp();
    n_cmp++; if (got !== e) begin n_err++; $display("FAIL lslp_rsp got=%h want=%h", got, e); end
    n_cmp++; if ({got.hi, got.lo} !== 16'h0102) begin n_err++; $display("FAIL lslp_16 got=%h want=0102", {got.hi, got.lo}); end
  endtask

  initial begin
    bus.req_valid = '0;
    for (int r = 0; r < NR; r++) bus.req_oper[r] = alu_op_add;
    bus.req_a_lo = '0;
    bus.req_a_hi = '0;
    bus.req_b = '0;
    bus.req_use_pflags = '0;
    bus.req_flags = '0;
    bus.req_upd_pflags = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_adc_chain();
    test_arbitration();
    test_backpressure();
    test_reset_mid_exec();
    test_16bit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
